// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared definitions for the instruction-fetch front end.
//            Holds the default address and instruction widths, the PC
//            increment in bytes, and the prefetch queue entry layout.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int C_ADDR_W   = 32;
  localparam int C_INST_W   = 32;
  localparam int INST_BYTES = C_INST_W / 8;

  // One prefetch queue entry. The PC is in the upper bits and the word in the
  // lower bits, so a flat vector of the same width packs as {pc, inst}.
  typedef struct packed {
    logic [C_ADDR_W-1:0] pc;
    logic [C_INST_W-1:0] inst;
  } fetch_entry_t;

  // Width that holds queue count plus one in-flight fetch without overflow.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous DEPTH-entry FIFO of prefetch entries with push,
//            pop and a dominant flush. Pointers wrap at DEPTH, so any legal
//            DEPTH >= 2 works, not only powers of two.
// Ports    : i_clk, i_rst_n  clock and asynchronous active-low reset
//            i_push, i_data  write an entry at the tail
//            i_pop           drop the head entry
//            i_flush         empty the FIFO (wins over push and pop)
//            o_head          head entry (meaningful while !o_empty)
//            o_count         number of stored entries, 0..DEPTH
//            o_empty, o_full occupancy flags
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_do_push;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [PTR_W-1:0] w_rptr_nxt;

  assign w_do_push  = i_push && !i_flush;
  assign w_do_pop   = i_pop && !i_flush && (r_count != '0);
  assign w_wptr_nxt = (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= w_wptr_nxt;
      if (w_do_pop)  r_rptr <= w_rptr_nxt;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: o_count qualifies every read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

  a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_flush && o_full));

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : Instruction-fetch front end. Holds the PC, issues sequential
//            fetches to a one-cycle-latency instruction memory, buffers the
//            returned words with their PCs in a prefetch queue and delivers
//            them to decode over valid/ready. A redirect flushes the queue,
//            drops in-flight data and restarts fetch at the aligned target.
// Ports    : Clk, Clrn                 clock, asynchronous active-low reset
//            imem_req/addr/rdata       instruction memory interface
//            redir_valid/redir_pc      branch/jump redirect
//            out_valid/ready/inst/pc   decode handshake
//            stat_fetch_cnt/flush_cnt  delivery / redirect counters
// Options  : FETCH_STATS_EN  when defined, the stat counters are built;
//            otherwise both stat outputs are tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = C_ADDR_W,
  parameter int                INST_W   = C_INST_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Clrn,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       stat_fetch_cnt,
  output logic [31:0]       stat_flush_cnt
);

  localparam int                c_entry_w = ADDR_W + INST_W;
  localparam int                c_cnt_w   = $clog2(DEPTH + 1);
  localparam int                c_occ_w   = occ_width(DEPTH);
  localparam logic [ADDR_W-1:0] c_pc_inc  = ADDR_W'(INST_W / 8);

  logic [ADDR_W-1:0]    r_pc;
  logic                 r_inflight;
  logic [ADDR_W-1:0]    r_inflight_pc;
  logic                 r_kill;

  logic [c_entry_w-1:0] w_head;
  logic [c_cnt_w-1:0]   w_count;
  logic                 w_empty;
  logic                 w_full;
  logic [c_occ_w-1:0]   w_occ;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_out_valid;

  // Occupancy counts the registered queue depth plus the outstanding fetch;
  // a pop in the same cycle is deliberately not credited.
  assign w_occ       = c_occ_w'(w_count) + c_occ_w'(r_inflight);
  assign w_issue     = !redir_valid && (w_occ < c_occ_w'(DEPTH));
  assign w_push      = r_inflight && !r_kill && !redir_valid;
  assign w_out_valid = !w_empty && !redir_valid;
  assign w_pop       = w_out_valid && out_ready;

  // Request is forced low while reset is held so the port shows its reset
  // value immediately on an asynchronous assertion.
  assign imem_req  = w_issue && Clrn;
  assign imem_addr = r_pc;
  assign out_valid = w_out_valid;
  assign out_pc    = w_empty ? '0 : w_head[c_entry_w-1 -: ADDR_W];
  assign out_inst  = w_empty ? '0 : w_head[INST_W-1:0];

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_kill        <= 1'b0;
    end else if (redir_valid) begin
      r_pc       <= {redir_pc[ADDR_W-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_kill     <= r_inflight;
    end else begin
      r_kill <= 1'b0;
      if (w_issue) begin
        r_pc          <= r_pc + c_pc_inc;
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (c_entry_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst_n (Clrn),
    .i_push  (w_push),
    .i_data  ({r_inflight_pc, imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (redir_valid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Target alignment discards the low address bits; the full flag is only
  // consumed by the FIFO's own overflow check.
  logic w_unused;
  assign w_unused = ^{redir_pc[1:0], w_full};

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pop)       r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (redir_valid) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stat_fetch_cnt = r_fetch_cnt;
  assign stat_flush_cnt = r_flush_cnt;
`else
  assign stat_fetch_cnt = '0;
  assign stat_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Purpose  : Self-checking bench for fetch_queue_unit. A queue-based model of
//            the fetch front end predicts every cycle's outputs; an
//            environment memory answers each request one cycle later.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        Clrn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] stat_fetch_cnt;
  logic [31:0] stat_flush_cnt;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .Clk            (clk),
    .Clrn           (Clrn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_flush_cnt (stat_flush_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_infl_pc;
  int unsigned m_fetch;
  int unsigned m_flush;

  // Environment memory state
  bit          last_req;
  logic [31:0] last_addr;
  bit          seen_valid;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc      = 32'h0;
    m_infl    = 0;
    m_infl_pc = 32'h0;
    m_fetch   = 0;
    m_flush   = 0;
    last_req  = 0;
    last_addr = 32'h0;
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_fetch_cnt", stat_fetch_cnt, 32'h0);
    check("rst_flush_cnt", stat_flush_cnt, 32'h0);
  endtask

  task automatic run_cycle(input bit rdy, input bit rd, input logic [31:0] rpc);
    bit   e_req;
    bit   e_valid;
    ent_t e;
    @(negedge clk);
    out_ready   = rdy;
    redir_valid = rd;
    redir_pc    = rpc;
    imem_rdata  = last_req ? mem_word(last_addr) : $urandom;
    #1;
    e_req   = !rd && ((m_q.size() + int'(m_infl)) < DEPTH);
    e_valid = (m_q.size() != 0) && !rd;
    check("imem_req", imem_req, e_req);
    if (e_req) check("imem_addr", imem_addr, m_pc);
    check("out_valid", out_valid, e_valid);
    if (e_valid) begin
      check("out_pc", out_pc, m_q[0].pc);
      check("out_inst", out_inst, m_q[0].inst);
    end
`ifdef FETCH_STATS_EN
    check("fetch_cnt", stat_fetch_cnt, m_fetch);
    check("flush_cnt", stat_flush_cnt, m_flush);
`else
    check("fetch_cnt", stat_fetch_cnt, 32'h0);
    check("flush_cnt", stat_flush_cnt, 32'h0);
`endif
    seen_valid = out_valid;
    last_req   = imem_req;
    last_addr  = imem_addr;
    @(posedge clk);
    if (rd) begin
      m_flush++;
      m_q.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_infl = 0;
    end else begin
      if (e_valid && rdy) begin
        void'(m_q.pop_front());
        m_fetch++;
      end
      if (m_infl) begin
        e.pc   = m_infl_pc;
        e.inst = mem_word(m_infl_pc);
        m_q.push_back(e);
      end
      if (e_req) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
        m_infl    = 1;
      end else begin
        m_infl = 0;
      end
    end
  endtask

  initial begin
    int first_valid;
    bit rdy;
    bit rd;
    logic [31:0] rpc;

    Clrn        = 1'b0;
    out_ready   = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    imem_rdata  = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_reset_outputs();
    @(posedge clk);
    #1 Clrn = 1'b1;

    // Streaming with decode always ready; first delivery in cycle 3.
    first_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      run_cycle(1'b1, 1'b0, 32'h0);
      if (first_valid == 0 && seen_valid) first_valid = i;
    end
    check("first_valid_cycle", first_valid, 3);

    // Decode stalls long enough for the queue to fill, then drains.
    repeat (10) run_cycle(1'b0, 1'b0, 32'h0);
    repeat (10) run_cycle(1'b1, 1'b0, 32'h0);

    // Asynchronous reset asserted between clock edges.
    @(negedge clk);
    #3 Clrn = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 Clrn = 1'b1;

    // Queue holds 3 with one in flight, then redirect to an unaligned target.
    repeat (4) run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b1, 32'h0000_0103);
    repeat (10) run_cycle(1'b1, 1'b0, 32'h0);

    // Redirect concurrent with a ready decode: nothing delivered that cycle.
    repeat (3) run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b1, 32'h0000_0200);
    run_cycle(1'b1, 1'b1, 32'h0000_0300);
    repeat (6) run_cycle(1'b1, 1'b0, 32'h0);

    // Address wrap at the top of the address space.
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
    repeat (8) run_cycle(1'b1, 1'b0, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else                           rpc = $urandom;
      run_cycle(rdy, rd, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
